// File: rtl/out_port_fifo_pkg.sv
// Shared constants and helpers for the processor output port FIFO.
package out_port_fifo_pkg;

    // Data word width, matching the 16-bit register file.
    localparam int DATA_W = 16;

    // Default number of buffered output words.
    localparam int OUT_PORT_DEPTH = 4;

    // Ceiling log2, used to derive pointer widths from a depth.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/out_port_fifo_if.sv
// Handshake bundle between the write-back stage, the output FIFO and the external consumer.
import out_port_fifo_pkg::*;

interface out_port_fifo_if #(
    parameter int Width = DATA_W,
    parameter int Depth = OUT_PORT_DEPTH
);
    localparam int AddrW = clog2(Depth);

    logic             wr_en;
    logic [Width-1:0] wr_data;
    logic             stall;
    logic [Width-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic [AddrW:0]   count;
    logic             overflow;

    // Driven by the pipeline and the consumer.
    modport master (
        output wr_en,
        output wr_data,
        output out_ready,
        input  stall,
        input  out_data,
        input  out_valid,
        input  count,
        input  overflow
    );

    // Driven by the FIFO.
    modport slave (
        input  wr_en,
        input  wr_data,
        input  out_ready,
        output stall,
        output out_data,
        output out_valid,
        output count,
        output overflow
    );

endinterface

// File: rtl/out_port_fifo_mem.sv
// Depth x Width register array: synchronous write, asynchronous read, cleared on reset.
module out_port_mem #(
    parameter int Width = 16,
    parameter int Depth = 4,
    parameter int AddrW = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AddrW-1:0] waddr,
    input  logic [Width-1:0] wdata,
    input  logic [AddrW-1:0] raddr,
    output logic [Width-1:0] rdata
);

    logic [Width-1:0] mem_q [Depth];
    logic [Width-1:0] mem_d [Depth];

    // Next array contents: only the addressed entry changes on a write.
    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[waddr] = wdata;
        end
    end

    // Storage registers, all cleared to zero so the read port shows 0 after reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_q <= '{default: '0};
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/out_port_fifo.sv
// Output port FIFO: buffers OUT-instruction words and hands them to a valid/ready consumer.
module out_port_fifo
    import out_port_fifo_pkg::*;
#(
    parameter int Width = DATA_W,
    parameter int Depth = OUT_PORT_DEPTH
) (
    input  logic           clk,
    input  logic           rst,
    out_port_fifo_if.slave bus
);

    localparam int              AddrW     = clog2(Depth);
    localparam logic [AddrW:0]   FullCount = (AddrW + 1)'(Depth);
    localparam logic [AddrW:0]   CountOne  = (AddrW + 1)'(1);
    localparam logic [AddrW-1:0] PtrOne    = (AddrW)'(1);

    logic [AddrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AddrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AddrW:0]   count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             full, empty, push, pop;
    logic [Width-1:0] head_data;

    // Handshake decode and next-state for pointers, occupancy and the sticky drop flag.
    always_comb begin
        full       = (count_q == FullCount);
        empty      = (count_q == '0);
        pop        = !empty && bus.out_ready;
        push       = bus.wr_en && (!full || pop);
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PtrOne;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrOne;
        end
        if (push && !pop) begin
            count_d = count_q + CountOne;
        end else if (pop && !push) begin
            count_d = count_q - CountOne;
        end
        if (bus.wr_en && !push) begin
            overflow_d = 1'b1;
        end
    end

    // Control state registers; pointers wrap through natural rollover.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    out_port_mem #(
        .Width(Width),
        .Depth(Depth),
        .AddrW(AddrW)
    ) u_mem (
        .clk  (clk),
        .rst  (rst),
        .we   (push),
        .waddr(wr_ptr_q),
        .wdata(bus.wr_data),
        .raddr(rd_ptr_q),
        .rdata(head_data)
    );

    // Outputs depend only on registered state, so stall never sees out_ready or wr_en.
    assign bus.out_valid = !empty;
    assign bus.out_data  = head_data;
    assign bus.stall     = full;
    assign bus.count     = count_q;
    assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_out_port_fifo.sv
// Self-checking bench for out_port_fifo: vector table, hand sequences and a randomized queue model.
module tb_out_port_fifo;
    import out_port_fifo_pkg::*;

    localparam int W = DATA_W;
    localparam int D = OUT_PORT_DEPTH;

    typedef struct {
        logic        wr_en;
        logic [15:0] wr_data;
        logic        out_ready;
        logic        exp_valid;
        logic        chk_data;
        logic [15:0] exp_data;
        logic [2:0]  exp_count;
        logic        exp_stall;
        logic        exp_ovf;
    } vec_t;

    logic clk;
    logic rst;

    out_port_fifo_if #(.Width(W), .Depth(D)) bus ();

    out_port_fifo #(.Width(W), .Depth(D)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks_total  = 0;
    int          checks_passed = 0;
    logic [15:0] model_q[$];
    logic        model_ovf;
    vec_t        vecs[16];

    // Single comparison with pass/fail bookkeeping.
    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks_total++;
        if (actual === expected) begin
            checks_passed++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Compare every output against the queue model.
    task automatic check_model(input string tag);
        check_output({tag, " out_valid"}, 32'(bus.out_valid), 32'(model_q.size() != 0));
        check_output({tag, " count"}, 32'(bus.count), 32'(model_q.size()));
        check_output({tag, " stall"}, 32'(bus.stall), 32'(model_q.size() == D));
        check_output({tag, " overflow"}, 32'(bus.overflow), 32'(model_ovf));
        if (model_q.size() != 0) begin
            check_output({tag, " out_data"}, 32'(bus.out_data), 32'(model_q[0]));
        end
    endtask

    // Drive one cycle of inputs, check no same-cycle effect, clock, then advance the model.
    task automatic apply_stimulus(input logic wr, input logic [15:0] data, input logic rdy);
        bit m_pop;
        bit m_push;
        bus.wr_en     = wr;
        bus.wr_data   = data;
        bus.out_ready = rdy;
        #1;
        check_output("pre-edge out_valid", 32'(bus.out_valid), 32'(model_q.size() != 0));
        check_output("pre-edge stall", 32'(bus.stall), 32'(model_q.size() == D));
        m_pop  = (model_q.size() != 0) && rdy;
        m_push = wr && ((model_q.size() < D) || m_pop);
        @(posedge clk);
        #1;
        if (m_pop) model_q.delete(0);
        if (m_push) model_q.push_back(data);
        if (wr && !m_push) model_ovf = 1'b1;
    endtask

    // Hold reset across an edge, then release away from the clock edge.
    task automatic do_reset();
        bus.wr_en     = 1'b0;
        bus.wr_data   = '0;
        bus.out_ready = 1'b0;
        rst           = 1'b0;
        model_q.delete();
        model_ovf = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        bus.wr_en     = 1'b0;
        bus.wr_data   = '0;
        bus.out_ready = 1'b0;
        rst           = 1'b0;
        model_q.delete();
        model_ovf = 1'b0;

        vecs[0]  = '{1'b1, 16'h1234, 1'b0, 1'b1, 1'b1, 16'h1234, 3'd1, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h1234, 3'd1, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h1234, 3'd1, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h1234, 3'd1, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 3'd0, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 16'h0001, 1'b0, 1'b1, 1'b1, 16'h0001, 3'd1, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 16'h0002, 1'b0, 1'b1, 1'b1, 16'h0001, 3'd2, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 16'h0003, 1'b0, 1'b1, 1'b1, 16'h0001, 3'd3, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 16'h0004, 1'b0, 1'b1, 1'b1, 16'h0001, 3'd4, 1'b1, 1'b0};
        vecs[9]  = '{1'b1, 16'hBEEF, 1'b1, 1'b1, 1'b1, 16'h0002, 3'd4, 1'b1, 1'b0};
        vecs[10] = '{1'b1, 16'hDEAD, 1'b0, 1'b1, 1'b1, 16'h0002, 3'd4, 1'b1, 1'b1};
        vecs[11] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h0003, 3'd3, 1'b0, 1'b1};
        vecs[12] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h0004, 3'd2, 1'b0, 1'b1};
        vecs[13] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'hBEEF, 3'd1, 1'b0, 1'b1};
        vecs[14] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 3'd0, 1'b0, 1'b1};
        vecs[15] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 3'd0, 1'b0, 1'b1};

        // Reset state while reset is held, then after release with idle inputs.
        repeat (2) @(posedge clk);
        #1;
        check_output("reset out_valid", 32'(bus.out_valid), 32'd0);
        check_output("reset stall", 32'(bus.stall), 32'd0);
        check_output("reset count", 32'(bus.count), 32'd0);
        check_output("reset out_data", 32'(bus.out_data), 32'd0);
        check_output("reset overflow", 32'(bus.overflow), 32'd0);
        rst = 1'b1;
        apply_stimulus(1'b0, 16'h0000, 1'b1);
        check_model("idle");
        check_output("idle out_data", 32'(bus.out_data), 32'd0);

        // Vector table: single push hold, fill, push-with-pop at full, dropped push, drain.
        for (int i = 0; i < 16; i++) begin
            apply_stimulus(vecs[i].wr_en, vecs[i].wr_data, vecs[i].out_ready);
            check_output($sformatf("vec%0d out_valid", i), 32'(bus.out_valid), 32'(vecs[i].exp_valid));
            check_output($sformatf("vec%0d count", i), 32'(bus.count), 32'(vecs[i].exp_count));
            check_output($sformatf("vec%0d stall", i), 32'(bus.stall), 32'(vecs[i].exp_stall));
            check_output($sformatf("vec%0d overflow", i), 32'(bus.overflow), 32'(vecs[i].exp_ovf));
            if (vecs[i].chk_data) begin
                check_output($sformatf("vec%0d out_data", i), 32'(bus.out_data), 32'(vecs[i].exp_data));
            end
            check_model($sformatf("vec%0d model", i));
        end

        // Fill with 0x0001..0x0004, then drain and expect them in order.
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(1'b1, 16'(i + 1), 1'b0);
        end
        check_output("fill stall", 32'(bus.stall), 32'd1);
        for (int i = 0; i < 4; i++) begin
            check_output($sformatf("drain%0d out_data", i), 32'(bus.out_data), 32'(i + 1));
            apply_stimulus(1'b0, 16'h0000, 1'b1);
            check_output($sformatf("drain%0d count", i), 32'(bus.count), 32'(3 - i));
        end

        // Pointer wrap with interleaved pushes and pops, then an asynchronous reset mid-stream.
        do_reset();
        for (int k = 0; k < 6; k++) begin
            apply_stimulus(1'b1, 16'h0100 + 16'(k), 1'b0);
            check_model($sformatf("wrap push%0d", k));
            apply_stimulus(1'b0, 16'h0000, 1'b1);
            check_model($sformatf("wrap pop%0d", k));
        end
        for (int k = 0; k < 5; k++) begin
            apply_stimulus(1'b1, 16'h0200 + 16'(k), 1'b0);
        end
        check_model("wrap full+drop");
        #2;
        rst = 1'b0;
        #1;
        check_output("async rst out_valid", 32'(bus.out_valid), 32'd0);
        check_output("async rst count", 32'(bus.count), 32'd0);
        check_output("async rst stall", 32'(bus.stall), 32'd0);
        check_output("async rst overflow", 32'(bus.overflow), 32'd0);
        check_output("async rst out_data", 32'(bus.out_data), 32'd0);
        bus.wr_en   = 1'b1;
        bus.wr_data = 16'h5555;
        @(posedge clk);
        #1;
        check_output("push during rst count", 32'(bus.count), 32'd0);
        rst       = 1'b1;
        bus.wr_en = 1'b0;
        model_q.delete();
        model_ovf = 1'b0;
        apply_stimulus(1'b1, 16'h00AA, 1'b0);
        check_output("post-rst first out_data", 32'(bus.out_data), 32'h00AA);
        check_output("post-rst first count", 32'(bus.count), 32'd1);
        check_model("post-rst");

        // Randomized traffic in phases with different push/pop pressure.
        do_reset();
        for (int phase = 0; phase < 4; phase++) begin
            int wr_pct;
            int rdy_pct;
            case (phase)
                0:       begin wr_pct = 80; rdy_pct = 30; end
                1:       begin wr_pct = 30; rdy_pct = 80; end
                2:       begin wr_pct = 60; rdy_pct = 50; end
                default: begin wr_pct = 95; rdy_pct = 20; end
            endcase
            for (int c = 0; c < 100; c++) begin
                apply_stimulus($urandom_range(0, 99) < wr_pct, 16'($urandom), $urandom_range(0, 99) < rdy_pct);
                check_model($sformatf("rand p%0d c%0d", phase, c));
            end
        end

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule

// File: doc/out_port_fifo.md
Name: out_port_fifo

Overview:
- Output-port counterpart of the processor's input port. The write-back stage of the five-stage pipeline pushes OUT-instruction data into this block.
- Words are buffered in a small FIFO and presented to an external consumer over a valid/ready handshake.
- When the buffer is full, the block asserts stall back to the pipeline.
- A sticky overflow flag records any word that was dropped.

Parameters:
- Width, 16, data word width (matches the 16-bit register file).
- Depth, 4, FIFO entries; must be a power of 2 and at least 2.
- AddrW, 2, pointer width, equal to log2(Depth); derived, not overridden.

Ports:
- clk  input  1  single system clock; all state updates on the posedge.
- rst  input  1  asynchronous, active-low reset.
- wr_en  input  1  push request from the write-back stage (OUT instruction).
- wr_data  input  Width  word to output.
- stall  output  1  buffer full; the pipeline must hold the OUT instruction.
- out_data  output  Width  head-of-FIFO word to the external consumer.
- out_valid  output  1  out_data holds an unconsumed word.
- out_ready  input  1  consumer accepts out_data this cycle.
- count  output  AddrW+1  number of occupied entries, 0..Depth.
- overflow  output  1  sticky flag: a push was dropped.

Behaviour:
- Reset (rst=0, asynchronous):
  - Pointers and count go to 0; out_valid=0, stall=0, overflow=0.
  - All storage entries go to 0, so out_data=0.
  - Any in-flight push or pop is discarded.
  - Release is synchronous to the next clk posedge.
- Signal definitions:
  - pop = out_valid && out_ready.
  - push = wr_en && (!full || pop).
  - full = (count == Depth); empty = (count == 0).
- Per posedge:
  - On push: mem[wr_ptr] <= wr_data and wr_ptr increments.
  - On pop: rd_ptr increments.
  - count changes by +1 on push only, -1 on pop only, and is unchanged when both or neither occur.
- Pointers wrap modulo Depth, using natural AddrW-bit rollover.
- Outputs:
  - out_valid = !empty.
  - out_data = mem[rd_ptr]. Its value is don't-care while out_valid=0, except that it reads 0 after reset.
  - stall = full. It is a function of state only, with no combinational path from out_ready or wr_en.
- Latency: a word pushed at edge N appears on out_data with out_valid=1 after edge N. There is no fall-through within the same cycle.
- Push and pop in the same cycle:
  - Both are accepted and count is unchanged.
  - When full, a simultaneous pop allows the push to be accepted.
  - When empty, pop cannot occur, so only the push takes effect.
- Full with wr_en=1 and no pop:
  - The word is dropped and storage is unchanged.
  - overflow <= 1 and stays set until reset.
  - A correctly stalled pipeline never triggers this.
- Empty with out_ready=1: no effect.
- Handshake rule: while out_valid=1 and out_ready=0, out_data and out_valid stay stable.

Decomposition:
- Shared package:
  - Constant for the data width (16).
  - Default out-port depth.
  - A clog2 helper for AddrW.
- One natural sub-module, out_port_mem: a Depth x Width register array with synchronous write, asynchronous read, and asynchronous reset.
- Pointer, count, flag and handshake logic stay in the top module.

Test Plan:
- Reset then idle -> out_valid=0, stall=0, count=0, out_data=0, overflow=0.
- Push 0x1234 with out_ready=0 -> after 1 edge: out_valid=1, out_data=0x1234, count=1; hold 3 cycles and out_data stays stable.
- Push 0x0001..0x0004 with out_ready=0 -> count=4 and stall=1. Then drive out_ready=1 -> words appear in order 0x0001..0x0004 and count returns to 0.
- Fill to full, then push 0xBEEF with pop in the same cycle -> push accepted, count stays 4, 0xBEEF emerges after the remaining 3 words, overflow=0.
- Fill to full, then push 0xDEAD with out_ready=0 -> word dropped, overflow=1 and sticky, count=4, contents unchanged.
- Fill with 6 pushes and 6 pops interleaved to exercise pointer wrap, then assert rst mid-stream -> all outputs return to reset values immediately, and the next push 0x00AA is seen first.
